// File: rtl/fpu_dot_seq.sv
// Dot-product sequencer driving a shared single-precision fpu: MUL then ADD per element.
// Define FPU_DOT_SQDIFF_EN to accumulate sum((x-y)^2) via an extra SUB step per element.
module fpu_dot_seq #(
  parameter int FPU_LATENCY = 1,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_x,
  input  logic [31:0]      in_y,
  input  logic             in_last,
  output logic [31:0]      fpu_a,
  output logic [31:0]      fpu_b,
  output logic [1:0]       fpu_opcode,
  input  logic [31:0]      fpu_o,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_sum,
  output logic [CNT_W-1:0] out_count,
  output logic             busy
);

  localparam int WCNT_W = (FPU_LATENCY < 1) ? 1 : $clog2(FPU_LATENCY + 1);

  localparam logic [1:0] OP_ADD = 2'b00;
  localparam logic [1:0] OP_SUB = 2'b01;
  localparam logic [1:0] OP_MUL = 2'b11;

  typedef enum logic [2:0] {
    ACCEPT,
    MUL_WAIT,
    ADD_WAIT,
`ifdef FPU_DOT_SQDIFF_EN
    SUB_WAIT,
`endif
    DONE
  } state_t;

  state_t             state_q, state_d;
  logic [WCNT_W-1:0]  wcnt_q, wcnt_d;
  logic [31:0]        acc_q, acc_d;
  logic [CNT_W-1:0]   count_q, count_d;
  logic               last_q, last_d;
  logic [31:0]        fpu_a_q, fpu_a_d;
  logic [31:0]        fpu_b_q, fpu_b_d;
  logic [1:0]         op_q, op_d;
  logic [31:0]        out_sum_q, out_sum_d;
  logic [CNT_W-1:0]   out_count_q, out_count_d;
  logic               out_valid_q, out_valid_d;
  logic               in_ready_q, in_ready_d;
  logic               busy_q, busy_d;
  logic               wait_done;

  // The fpu result is trusted once operands have been held for FPU_LATENCY cycles.
  assign wait_done = (wcnt_q == WCNT_W'(FPU_LATENCY));

  always_comb begin
    state_d     = state_q;
    wcnt_d      = wcnt_q;
    acc_d       = acc_q;
    count_d     = count_q;
    last_d      = last_q;
    fpu_a_d     = fpu_a_q;
    fpu_b_d     = fpu_b_q;
    op_d        = op_q;
    out_sum_d   = out_sum_q;
    out_count_d = out_count_q;
    out_valid_d = out_valid_q;
    unique case (state_q)
      ACCEPT: begin
        if (in_valid && in_ready_q) begin
          last_d  = in_last;
          fpu_a_d = in_x;
          fpu_b_d = in_y;
          wcnt_d  = '0;
          if (count_q != '1) count_d = count_q + CNT_W'(1);
`ifdef FPU_DOT_SQDIFF_EN
          op_d    = OP_SUB;
          state_d = SUB_WAIT;
`else
          op_d    = OP_MUL;
          state_d = MUL_WAIT;
`endif
        end
      end
`ifdef FPU_DOT_SQDIFF_EN
      SUB_WAIT: begin
        if (wait_done) begin
          fpu_a_d = fpu_o;
          fpu_b_d = fpu_o;
          op_d    = OP_MUL;
          wcnt_d  = '0;
          state_d = MUL_WAIT;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
`endif
      MUL_WAIT: begin
        if (wait_done) begin
          fpu_a_d = acc_q;
          fpu_b_d = fpu_o;
          op_d    = OP_ADD;
          wcnt_d  = '0;
          state_d = ADD_WAIT;
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      ADD_WAIT: begin
        if (wait_done) begin
          acc_d  = fpu_o;
          wcnt_d = '0;
          if (last_q) begin
            out_sum_d   = fpu_o;
            out_count_d = count_q;
            out_valid_d = 1'b1;
            state_d     = DONE;
          end else begin
            state_d = ACCEPT;
          end
        end else begin
          wcnt_d = wcnt_q + WCNT_W'(1);
        end
      end
      DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          acc_d       = '0;
          count_d     = '0;
          state_d     = ACCEPT;
        end
      end
      default: state_d = ACCEPT;
    endcase
    in_ready_d = (state_d == ACCEPT);
    busy_d     = !((state_d == ACCEPT) && (acc_d == '0) && (count_d == '0));
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ACCEPT;
      wcnt_q      <= '0;
      acc_q       <= '0;
      count_q     <= '0;
      last_q      <= 1'b0;
      fpu_a_q     <= '0;
      fpu_b_q     <= '0;
      op_q        <= OP_ADD;
      out_sum_q   <= '0;
      out_count_q <= '0;
      out_valid_q <= 1'b0;
      in_ready_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      wcnt_q      <= wcnt_d;
      acc_q       <= acc_d;
      count_q     <= count_d;
      last_q      <= last_d;
      fpu_a_q     <= fpu_a_d;
      fpu_b_q     <= fpu_b_d;
      op_q        <= op_d;
      out_sum_q   <= out_sum_d;
      out_count_q <= out_count_d;
      out_valid_q <= out_valid_d;
      in_ready_q  <= in_ready_d;
      busy_q      <= busy_d;
    end
  end

  assign in_ready   = in_ready_q;
  assign fpu_a      = fpu_a_q;
  assign fpu_b      = fpu_b_q;
  assign fpu_opcode = op_q;
  assign out_valid  = out_valid_q;
  assign out_sum    = out_sum_q;
  assign out_count  = out_count_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_fpu_dot_seq.sv
// Bench for fpu_dot_seq: behavioural fpu model plus a queue of expected {sum, count} results.
module tb_fpu_dot_seq;

  localparam int LAT = 1;
  localparam int CW  = 3;
`ifdef FPU_DOT_SQDIFF_EN
  localparam int EXP_WAIT = 3 * (LAT + 1);
`else
  localparam int EXP_WAIT = 2 * (LAT + 1);
`endif

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [31:0]   in_x = '0;
  logic [31:0]   in_y = '0;
  logic          in_last = 1'b0;
  logic [31:0]   fpu_a, fpu_b, fpu_o;
  logic [1:0]    fpu_opcode;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [31:0]   out_sum;
  logic [CW-1:0] out_count;
  logic          busy;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [31:0]   sum;
    logic [CW-1:0] cnt;
  } exp_t;
  exp_t sb_q[$];

  fpu_dot_seq #(.FPU_LATENCY(LAT), .CNT_W(CW)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_x(in_x), .in_y(in_y), .in_last(in_last),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_opcode(fpu_opcode), .fpu_o(fpu_o),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_sum(out_sum), .out_count(out_count), .busy(busy)
  );

  always #5 clk = ~clk;

  function automatic real sp2r(input logic [31:0] b);
    logic [63:0] d;
    if (b[30:0] == 31'd0) d = {b[31], 63'd0};
    else d = {b[31], ({3'b000, b[30:23]} + 11'd896), b[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  function automatic logic [31:0] r2sp(input real r);
    logic [63:0] d;
    logic [10:0] e;
    d = $realtobits(r);
    if (d[62:0] == 63'd0) return {d[63], 31'd0};
    e = d[62:52] - 11'd896;
    return {d[63], e[7:0], d[51:29]};
  endfunction

  function automatic logic [31:0] fpu_calc(input logic [31:0] a, input logic [31:0] b,
                                           input logic [1:0] op);
    real ra, rb;
    ra = sp2r(a);
    rb = sp2r(b);
    case (op)
      2'b00:   return r2sp(ra + rb);
      2'b01:   return r2sp(ra - rb);
      2'b10:   return r2sp(ra / rb);
      default: return r2sp(ra * rb);
    endcase
  endfunction

  // Behavioural fpu: result appears LAT cycles after its operands are registered.
  logic [31:0] fpu_pipe [LAT];
  always @(posedge clk) begin
    fpu_pipe[0] <= fpu_calc(fpu_a, fpu_b, fpu_opcode);
    for (int i = 1; i < LAT; i++) fpu_pipe[i] <= fpu_pipe[i-1];
  end
  assign fpu_o = fpu_pipe[LAT-1];

  task automatic drive_elem(input logic [31:0] x, input logic [31:0] y, input logic last,
                            output bit to);
    int n;
    n = 0;
    to = 1'b0;
    in_x = x; in_y = y; in_last = last; in_valid = 1'b1;
    while (!in_ready && n < 50) begin @(negedge clk); n++; end
    if (!in_ready) to = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic collect(output logic [31:0] s, output logic [CW-1:0] c, output int waited,
                         output bit to);
    waited = 0;
    while (!out_valid && waited < 60) begin @(negedge clk); waited++; end
    to = !out_valid;
    s  = out_sum;
    c  = out_count;
    if (!to) begin
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%0b want=0", out_valid); end
    total++; if (fpu_opcode !== 2'b00) begin bad++; $display("FAIL reset_opcode got=%b want=00", fpu_opcode); end
    total++; if ({fpu_a, fpu_b} !== 64'd0) begin bad++; $display("FAIL reset_operands got=%h_%h want=0", fpu_a, fpu_b); end
    total++; if ({out_sum, out_count} !== '0) begin bad++; $display("FAIL reset_outputs got=%h/%0d want=0/0", out_sum, out_count); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b want=0", busy); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%0b want=1", in_ready); end
  endtask

  task automatic test_basic();
    logic [31:0] xs [3];
    logic [31:0] ys [3];
    logic [31:0] s;
    logic [CW-1:0] c;
    int w;
    bit to;
    exp_t e;
    xs = '{32'h3F800000, 32'h40000000, 32'h40400000};
    ys = '{32'h40800000, 32'h40A00000, 32'h40C00000};
`ifdef FPU_DOT_SQDIFF_EN
    sb_q.push_back('{sum: 32'h41D80000, cnt: 3'd3});
`else
    sb_q.push_back('{sum: 32'h42000000, cnt: 3'd3});
`endif
    for (int i = 0; i < 3; i++) begin
      drive_elem(xs[i], ys[i], (i == 2), to);
      total++; if (to) begin bad++; $display("FAIL basic_accept_timeout elem=%0d", i); end
      if (i == 0) begin
`ifdef FPU_DOT_SQDIFF_EN
        total++; if (fpu_opcode !== 2'b01) begin bad++; $display("FAIL basic_first_op got=%b want=01", fpu_opcode); end
`else
        total++; if (fpu_opcode !== 2'b11) begin bad++; $display("FAIL basic_first_op got=%b want=11", fpu_opcode); end
`endif
        total++; if ({fpu_a, fpu_b} !== {xs[0], ys[0]}) begin bad++; $display("FAIL basic_first_operands got=%h_%h want=%h_%h", fpu_a, fpu_b, xs[0], ys[0]); end
        total++; if (in_ready !== 1'b0 || busy !== 1'b1) begin bad++; $display("FAIL basic_wait_flags got=ready%0b_busy%0b want=ready0_busy1", in_ready, busy); end
      end
    end
    collect(s, c, w, to);
    e = sb_q.pop_front();
    total++; if (to) begin bad++; $display("FAIL basic_out_timeout"); end
    total++; if (w !== EXP_WAIT) begin bad++; $display("FAIL basic_latency got=%0d want=%0d", w, EXP_WAIT); end
    total++; if (s !== e.sum) begin bad++; $display("FAIL basic_sum got=%h want=%h", s, e.sum); end
    total++; if (c !== e.cnt) begin bad++; $display("FAIL basic_count got=%0d want=%0d", c, e.cnt); end
  endtask

  task automatic test_single();
    logic [31:0] s;
    logic [CW-1:0] c;
    int w;
    bit to;
    exp_t e;
`ifdef FPU_DOT_SQDIFF_EN
    sb_q.push_back('{sum: 32'h3F800000, cnt: 3'd1});
`else
    sb_q.push_back('{sum: 32'h40C00000, cnt: 3'd1});
`endif
    drive_elem(32'h40000000, 32'h40400000, 1'b1, to);
    collect(s, c, w, to);
    e = sb_q.pop_front();
    total++; if (to || s !== e.sum) begin bad++; $display("FAIL single_sum got=%h want=%h", s, e.sum); end
    total++; if (c !== e.cnt) begin bad++; $display("FAIL single_count got=%0d want=%0d", c, e.cnt); end
  endtask

  task automatic test_cancel();
    logic [31:0] s;
    logic [CW-1:0] c;
    int w;
    bit to;
    exp_t e;
`ifdef FPU_DOT_SQDIFF_EN
    sb_q.push_back('{sum: 32'h41200000, cnt: 3'd2});
`else
    sb_q.push_back('{sum: 32'h00000000, cnt: 3'd2});
`endif
    drive_elem(32'h3F800000, 32'h40000000, 1'b0, to);
    drive_elem(32'h3F800000, 32'hC0000000, 1'b1, to);
    collect(s, c, w, to);
    e = sb_q.pop_front();
    total++; if (to || s !== e.sum) begin bad++; $display("FAIL cancel_sum got=%h want=%h", s, e.sum); end
    total++; if (c !== e.cnt) begin bad++; $display("FAIL cancel_count got=%0d want=%0d", c, e.cnt); end
  endtask

  task automatic test_backpressure();
    logic [31:0] s;
    logic [CW-1:0] c;
    int w;
    bit to;
    exp_t e;
`ifdef FPU_DOT_SQDIFF_EN
    sb_q.push_back('{sum: 32'h3F800000, cnt: 3'd1});
`else
    sb_q.push_back('{sum: 32'h40000000, cnt: 3'd1});
`endif
    drive_elem(32'h3F800000, 32'h40000000, 1'b1, to);
    w = 0;
    while (!out_valid && w < 60) begin @(negedge clk); w++; end
    e = sb_q.pop_front();
    for (int i = 0; i < 5; i++) begin
      total++;
      if (out_valid !== 1'b1 || out_sum !== e.sum || out_count !== e.cnt || in_ready !== 1'b0) begin
        bad++;
        $display("FAIL bp_hold cyc=%0d got=v%0b_%h_%0d_r%0b want=v1_%h_%0d_r0",
                 i, out_valid, out_sum, out_count, in_ready, e.sum, e.cnt);
      end
      @(negedge clk);
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    total++; if (out_valid !== 1'b0 || in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=v%0b_r%0b want=v0_r1", out_valid, in_ready); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL bp_idle_busy got=%0b want=0", busy); end
`ifdef FPU_DOT_SQDIFF_EN
    sb_q.push_back('{sum: 32'h41100000, cnt: 3'd1});
`else
    sb_q.push_back('{sum: 32'h40800000, cnt: 3'd1});
`endif
    drive_elem(32'h3F800000, 32'h40800000, 1'b1, to);
    collect(s, c, w, to);
    e = sb_q.pop_front();
    total++; if (to || s !== e.sum || c !== e.cnt) begin bad++; $display("FAIL bp_next_vector got=%h/%0d want=%h/%0d", s, c, e.sum, e.cnt); end
  endtask

  task automatic test_reset_mid();
    logic [31:0] s;
    logic [CW-1:0] c;
    int w;
    bit to;
    exp_t e;
    drive_elem(32'h40000000, 32'h40000000, 1'b0, to);
    w = 0;
    while (!in_ready && w < 60) begin @(negedge clk); w++; end
    drive_elem(32'h40400000, 32'h40400000, 1'b0, to);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    total++; if (out_valid !== 1'b0 || fpu_opcode !== 2'b00) begin bad++; $display("FAIL midrst_state got=v%0b_op%b want=v0_op00", out_valid, fpu_opcode); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL midrst_busy got=%0b want=0", busy); end
    @(negedge clk);
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midrst_in_ready got=%0b want=1", in_ready); end
`ifdef FPU_DOT_SQDIFF_EN
    sb_q.push_back('{sum: 32'h41100000, cnt: 3'd1});
`else
    sb_q.push_back('{sum: 32'h40800000, cnt: 3'd1});
`endif
    drive_elem(32'h3F800000, 32'h40800000, 1'b1, to);
    collect(s, c, w, to);
    e = sb_q.pop_front();
    total++; if (to || s !== e.sum || c !== e.cnt) begin bad++; $display("FAIL midrst_result got=%h/%0d want=%h/%0d", s, c, e.sum, e.cnt); end
  endtask

  task automatic test_saturate();
    logic [31:0] s;
    logic [CW-1:0] c;
    int w;
    bit to;
    exp_t e;
    // Nine elements with a 3-bit counter: count pins at 7 while the sum keeps growing.
`ifdef FPU_DOT_SQDIFF_EN
    sb_q.push_back('{sum: 32'h00000000, cnt: 3'd7});
`else
    sb_q.push_back('{sum: 32'h41100000, cnt: 3'd7});
`endif
    for (int i = 0; i < 9; i++) drive_elem(32'h3F800000, 32'h3F800000, (i == 8), to);
    collect(s, c, w, to);
    e = sb_q.pop_front();
    total++; if (to || s !== e.sum) begin bad++; $display("FAIL sat_sum got=%h want=%h", s, e.sum); end
    total++; if (c !== e.cnt) begin bad++; $display("FAIL sat_count got=%0d want=%0d", c, e.cnt); end
  endtask

  initial begin
    @(negedge clk);
    test_reset();
    test_basic();
    test_single();
    test_cancel();
    test_backpressure();
    test_reset_mid();
    test_saturate();
    total++; if (sb_q.size() != 0) begin bad++; $display("FAIL scoreboard_drain got=%0d want=0", sb_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
